ham_frame_accum: RTL and testbench

//   Downstream consumer of the Hamming-weight stage. Accepts one N-bit weight per

---
 rtl/ham_frame_accum.sv | 135 +++++++++++++
 tb/tb_ham_frame_accum.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham_frame_accum.sv
// ham_frame_accum
//   Sums FRAME_LEN unsigned Hamming weights into a saturating frame total and
//   presents it with a threshold-compare flag over a valid/ready handshake.
//   Typical use: per-frame bit-error counting (weight of A^B per word in,
//   error count per frame out).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous abort: drops the partial frame and any held result
//   in_valid     weight is valid
//   in_ready     block can accept a weight this cycle (high in ACCUM)
//   weight       N-bit Hamming weight of one word
//   threshold    compare limit, sampled on the frame-completing transfer
//   out_valid    total/over_thresh/saturated are valid (high in HOLD)
//   out_ready    consumer takes the result
//   total        saturating sum of the frame's weights
//   over_thresh  total > threshold (unsigned, strict)
//   saturated    the running sum reached all-ones at some point in the frame
module ham_frame_accum #(
    parameter int N         = 8,
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     weight,
    input  logic [ACC_W-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] total,
    output logic             over_thresh,
    output logic             saturated
);

    // A one-word frame still needs a 1-bit counter so the ports stay legal.
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] ALL_ONES = {ACC_W{1'b1}};

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_flag_r;

    logic [ACC_W-1:0] acc_next_s;
    logic             sat_next_s;
    logic             last_s;

    // Saturating add with one guard bit: any carry out clamps to all-ones.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [N-1:0]     w);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + (ACC_W+1)'(w);
        if (sum[ACC_W]) begin
            sat_add = ALL_ONES;
        end else begin
            sat_add = sum[ACC_W-1:0];
        end
    endfunction

    // Handshake outputs are decoded purely from the state register.
    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == HOLD);

    // Next accumulator value and sticky saturation flag for the current weight.
    always_comb begin
        acc_next_s = sat_add(acc_r, weight);
        // Clamped results are all-ones too, so one compare covers both cases.
        if (acc_next_s == ALL_ONES) begin
            sat_next_s = 1'b1;
        end else begin
            sat_next_s = sat_flag_r;
        end
        last_s = (cnt_r == LAST_CNT);
    end

    // Frame accumulation, result hold and handshake state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sat_flag_r  <= 1'b0;
            total       <= {ACC_W{1'b0}};
            over_thresh <= 1'b0;
            saturated   <= 1'b0;
        end else if (clear) begin
            // Abort discards the frame and any pending result; the last
            // published result registers keep their values.
            state_r    <= ACCUM;
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sat_flag_r <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (in_valid) begin
                        if (last_s) begin
                            total       <= acc_next_s;
                            saturated   <= sat_next_s;
                            over_thresh <= (acc_next_s > threshold);
                            acc_r       <= {ACC_W{1'b0}};
                            cnt_r       <= {CNT_W{1'b0}};
                            sat_flag_r  <= 1'b0;
                            state_r     <= HOLD;
                        end else begin
                            acc_r      <= acc_next_s;
                            cnt_r      <= cnt_r + CNT_W'(1);
                            sat_flag_r <= sat_next_s;
                        end
                    end
                end
                HOLD: begin
                    // No bypass: the next weight is only taken once back in ACCUM.
                    if (out_ready) begin
                        state_r <= ACCUM;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ham_frame_accum.sv
// tb_ham_frame_accum
//   Drives two instances (16-bit/16-word and 8-bit/4-word) through reset,
//   nominal, backpressure, clear, reset-in-hold and saturation scenarios and
//   compares against a frame-level arithmetic model.
module tb_ham_frame_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, in_valid, out_ready, sel_b;
    logic [7:0]  weight;
    logic [15:0] thr;

    logic        a_in_ready, a_out_valid, a_over, a_sat;
    logic [15:0] a_total;
    logic        b_in_ready, b_out_valid, b_over, b_sat;
    logic [7:0]  b_total;
    logic        cur_in_ready, cur_out_valid, cur_over, cur_sat;
    logic [15:0] cur_total;

    int checks   = 0;
    int failures = 0;
    int rises    = 0;
    logic ov_prev = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    ham_frame_accum #(.N(8), .FRAME_LEN(16), .ACC_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear & ~sel_b),
        .in_valid(in_valid & ~sel_b), .in_ready(a_in_ready),
        .weight(weight), .threshold(thr),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel_b),
        .total(a_total), .over_thresh(a_over), .saturated(a_sat)
    );

    ham_frame_accum #(.N(8), .FRAME_LEN(4), .ACC_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear & sel_b),
        .in_valid(in_valid & sel_b), .in_ready(b_in_ready),
        .weight(weight), .threshold(thr[7:0]),
        .out_valid(b_out_valid), .out_ready(out_ready & sel_b),
        .total(b_total), .over_thresh(b_over), .saturated(b_sat)
    );

    assign cur_in_ready  = sel_b ? b_in_ready  : a_in_ready;
    assign cur_out_valid = sel_b ? b_out_valid : a_out_valid;
    assign cur_over      = sel_b ? b_over      : a_over;
    assign cur_sat       = sel_b ? b_sat       : a_sat;
    assign cur_total     = sel_b ? {8'd0, b_total} : a_total;

    // Count rising edges of out_valid on instance A.
    always @(posedge clk) begin
        if (a_out_valid && !ov_prev) rises = rises + 1;
        ov_prev = a_out_valid;
    end

    // Frame-level reference: running sum clamped at 2^aw-1.
    task automatic model(input int w[$], input longint t, input int aw,
                         output longint tot, output bit s, output bit o);
        longint mx;
        mx  = (longint'(1) << aw) - 1;
        tot = 0;
        s   = 1'b0;
        foreach (w[i]) begin
            tot = tot + w[i];
            if (tot >= mx) begin
                tot = mx;
                s   = 1'b1;
            end
        end
        o = (tot > t);
    endtask

    // Send one full frame on the selected instance, then check the result.
    task automatic run_frame(input int w[$], input logic [15:0] t,
                             input string nm, input bit gaps);
        longint et;
        bit es, eo;
        model(w, longint'(t), sel_b ? 8 : 16, et, es, eo);
        thr = t;
        foreach (w[i]) begin
            if (gaps) begin
                in_valid = 1'b0;
                weight   = 8'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            checks++;
            if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s accum_state word %0d: in_ready=%0b out_valid=%0b want 1/0",
                         nm, i, cur_in_ready, cur_out_valid);
            end
            in_valid = 1'b1;
            weight   = 8'(w[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        // Threshold is sampled on the completing transfer; later changes are irrelevant.
        if (gaps) thr = 16'($urandom);
        checks++;
        if (cur_out_valid !== 1'b1 || cur_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s hold_state: out_valid=%0b in_ready=%0b want 1/0",
                     nm, cur_out_valid, cur_in_ready);
        end
        checks++;
        if (cur_total !== 16'(et)) begin
            failures++;
            $display("FAIL %s total: got %0d want %0d", nm, cur_total, et);
        end
        checks++;
        if (cur_over !== eo || cur_sat !== es) begin
            failures++;
            $display("FAIL %s flags: over=%0b sat=%0b want %0b/%0b", nm, cur_over, cur_sat, eo, es);
        end
    endtask

    // Hand the held result to the consumer and check the return to ACCUM.
    task automatic take_result(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release: out_valid=%0b in_ready=%0b want 0/1",
                     nm, cur_out_valid, cur_in_ready);
        end
    endtask

    task automatic test_reset();
        int w[$];
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel_b = 1'b0; weight = 8'd0; thr = 16'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_total !== 16'd0 ||
            a_over !== 1'b0 || a_sat !== 1'b0 || b_out_valid !== 1'b0 || b_total !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: a ov=%0b ir=%0b tot=%0d b ov=%0b tot=%0d want 0/1/0 0/0",
                     a_out_valid, a_in_ready, a_total, b_out_valid, b_total);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle out_valid: got %0b want 0", a_out_valid);
            end
        end
        // Get into HOLD with a nonzero total, then reset asynchronously mid-cycle.
        for (int i = 0; i < 16; i++) w.push_back(5);
        run_frame(w, 16'd0, "reset_prep", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_total !== 16'd0) begin
            failures++;
            $display("FAIL reset_async: out_valid=%0b in_ready=%0b total=%0d want 0/1/0",
                     a_out_valid, a_in_ready, a_total);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_release out_valid: got %0b want 0", a_out_valid);
            end
        end
    endtask

    task automatic test_nominal();
        int w[$];
        for (int i = 0; i < 16; i++) w.push_back(3);
        run_frame(w, 16'd40, "nominal_thr40", 1'b1);
        take_result("nominal_thr40");
        run_frame(w, 16'd48, "nominal_thr48", 1'b1);
        take_result("nominal_thr48");
        for (int f = 0; f < 3; f++) begin
            w.delete();
            for (int i = 0; i < 16; i++) w.push_back(int'($urandom_range(0, 255)));
            run_frame(w, 16'($urandom_range(0, 4080)), "nominal_rand", 1'b1);
            take_result("nominal_rand");
        end
    endtask

    task automatic test_backpressure();
        int w[$];
        for (int i = 0; i < 16; i++) w.push_back(3);
        run_frame(w, 16'd40, "bp_frame", 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            weight   = 8'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_total !== 16'd48 ||
                a_over !== 1'b1 || a_sat !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: ir=%0b ov=%0b tot=%0d over=%0b sat=%0b want 0/1/48/1/0",
                         c, a_in_ready, a_out_valid, a_total, a_over, a_sat);
            end
        end
        // in_valid stays high through the release cycle: it must not be taken.
        take_result("bp_release");
        in_valid = 1'b0;
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(1);
        run_frame(w, 16'd15, "bp_next_frame", 1'b1);
        take_result("bp_next_frame");
    endtask

    task automatic test_clear();
        int w[$];
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            weight   = 8'd8;
            @(negedge clk);
        end
        clear = 1'b1; in_valid = 1'b1; weight = 8'd8;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_partial: out_valid=%0b in_ready=%0b want 0/1", a_out_valid, a_in_ready);
        end
        for (int i = 0; i < 16; i++) w.push_back(1);
        run_frame(w, 16'd20, "clear_after", 1'b1);
        take_result("clear_after");
        // Clear while holding a result: the result is dropped but stays on total.
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(4);
        run_frame(w, 16'd10, "clear_hold_prep", 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_total !== 16'd64 || a_over !== 1'b1) begin
            failures++;
            $display("FAIL clear_hold: ov=%0b ir=%0b tot=%0d over=%0b want 0/1/64/1",
                     a_out_valid, a_in_ready, a_total, a_over);
        end
    endtask

    task automatic test_reset_in_hold();
        int w[$];
        int base;
        for (int i = 0; i < 16; i++) w.push_back(2);
        run_frame(w, 16'd0, "rih_prep", 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = rises;
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(8);
        run_frame(w, 16'd127, "rih_frame", 1'b1);
        take_result("rih_frame");
        repeat (2) @(negedge clk);
        checks++;
        if (rises - base !== 1) begin
            failures++;
            $display("FAIL rih_out_valid_count: got %0d want 1", rises - base);
        end
    endtask

    task automatic test_saturation();
        int w[$];
        sel_b = 1'b1;
        @(negedge clk);
        w = '{200, 100, 0, 5};
        run_frame(w, 16'd254, "sat_clamp", 1'b1);
        take_result("sat_clamp");
        w = '{255, 0, 0, 0};
        run_frame(w, 16'd255, "sat_exact", 1'b0);
        take_result("sat_exact");
        w = '{10, 20, 30, 40};
        run_frame(w, 16'd100, "sat_none", 1'b1);
        take_result("sat_none");
        for (int f = 0; f < 4; f++) begin
            w.delete();
            for (int i = 0; i < 4; i++) w.push_back(int'($urandom_range(0, 255)));
            run_frame(w, 16'($urandom_range(0, 255)), "sat_rand", 1'b1);
            take_result("sat_rand");
        end
        sel_b = 1'b0;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_clear();
        test_reset_in_hold();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
